hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rf_wen_idex  input  1  instruction in EX writes the register file.
REQ-004 mem2reg_idex  input  1  instruction in EX is a load (result comes from data memory).
REQ-005 rdest_ex  input  4  destination register number of the instruction in EX.
REQ-006 rs1_id, rs2_id  input  4 each  source register numbers of the instruction in ID.
REQ-007 use_rs1_id, use_rs2_id  input  1 each  instruction in ID actually reads rs1/rs2.
REQ-008 redirect_ex  input  1  taken branch, jal or jr resolved in EX this cycle.
REQ-009 pc_stall  output  1  hold PC.
REQ-010 ifid_stall  output  1  hold the IF/ID register.
REQ-011 idex_bubble  output  1  load a NOP (all control fields 0) into ID/EX at the next edge.
REQ-012 ifid_flush  output  1  load a NOP into IF/ID at the next edge.
REQ-013 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-014 Load-use hazard (lu) = mem2reg_idex & rf_wen_idex & ((use_rs1_id & rs1_id==rdest_ex) | (use_rs2_id & rs2_id==rdest_ex)).
REQ-015 FSM states: RUN, LSTALL, FLUSH. Outputs are Mealy: decoded combinationally from state and inputs.
REQ-016 RUN, redirect_ex=1: assert ifid_flush=1 and idex_bubble=1 this cycle. Next state FLUSH. flush_cnt increments.
REQ-017 RUN, redirect_ex=0, lu=1: assert pc_stall=1, ifid_stall=1 and idex_bubble=1 this cycle. Next state LSTALL. stall_cnt increments.
REQ-018 RUN, neither condition: all control outputs 0. Stay in RUN.
REQ-019 Simultaneous redirect_ex and lu: redirect wins. No stall. stall_cnt unchanged.
REQ-020 LSTALL: all control outputs 0. Next state RUN unconditionally. This gives exactly one bubble per load-use.
REQ-021 FLUSH: ifid_flush=1, and the other control outputs 0. This squashes the single wrong-path fetch issued before the PC redirect took effect. Next state RUN unconditionally. The inputs are ignored in this state.
REQ-022 Counters: 16-bit unsigned. Each holds at 0xFFFF and does not wrap.
REQ-023 Latency: hazard response is in the same cycle (zero-cycle). The state change is visible at the next edge.

Reset
REQ-024 While rst=1: state=RUN, stall_cnt=0, flush_cnt=0, and pc_stall, ifid_stall, idex_bubble and ifid_flush are all forced to 0.
REQ-025 Reset asserted in LSTALL or FLUSH aborts the sequence immediately. After release, the block evaluates from RUN on the first edge.

Structure
REQ-026 A shared package hazard_pkg holds the state enum (RUN, LSTALL, FLUSH) and the constant REG_AW=4.
REQ-027 One sub-module, sat_counter16 (clk, rst, inc, count), is instantiated twice, for stall_cnt and for flush_cnt.

Verification
REQ-028 Load r3 in EX (mem2reg=1, rf_wen=1, rdest=3), ID reads rs1=3 with use_rs1=1:
- cycle 0: pc_stall=ifid_stall=idex_bubble=1.
- cycle 1: all control outputs 0.
- stall_cnt=1.
REQ-029 Same load, ID reads rs1=3 but use_rs1=0 -> no stall, stall_cnt=0.
REQ-030 redirect_ex=1 while in RUN:
- cycle 0: ifid_flush=idex_bubble=1.
- cycle 1: ifid_flush=1 only.
- cycle 2: all 0.
- flush_cnt=1.
REQ-031 redirect_ex=1 and lu=1 in the same cycle -> flush sequence only, pc_stall=0, stall_cnt=0.
REQ-032 Preload stall_cnt at 0xFFFE, trigger 3 load-use events -> stall_cnt=0xFFFF and holds.
REQ-033 Assert rst mid-FLUSH -> outputs 0 immediately. After release with no hazard, state=RUN and counters=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   REG_AW       : register-number width
//   CNT_W        : event-counter width
//   hz_state_e   : controller state (RUN, LSTALL, FLUSH)
//   load_use()   : load-use hazard detect between EX and ID
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } hz_state_e;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic load_use(
        input logic              mem2reg,
        input logic              rf_wen,
        input logic [REG_AW-1:0] rdest,
        input logic [REG_AW-1:0] rs1,
        input logic              use_rs1,
        input logic [REG_AW-1:0] rs2,
        input logic              use_rs2
    );
        logic hit1;
        logic hit2;
        hit1 = use_rs1 & (rs1 == rdest);
        hit2 = use_rs2 & (rs2 == rdest);
        return mem2reg & rf_wen & (hit1 | hit2);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Pipeline -> controller : rf_wen_idex, mem2reg_idex, rdest_ex, rs1_id,
//                            rs2_id, use_rs1_id, use_rs2_id, redirect_ex
//   Controller -> pipeline : pc_stall, ifid_stall, idex_bubble, ifid_flush,
//                            stall_cnt, flush_cnt
//   modport master : pipeline side
//   modport slave  : hazard controller side
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic              rf_wen_idex;
    logic              mem2reg_idex;
    logic [REG_AW-1:0] rdest_ex;
    logic [REG_AW-1:0] rs1_id;
    logic [REG_AW-1:0] rs2_id;
    logic              use_rs1_id;
    logic              use_rs2_id;
    logic              redirect_ex;

    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              ifid_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rf_wen_idex, mem2reg_idex, rdest_ex, rs1_id, rs2_id,
               use_rs1_id, use_rs2_id, redirect_ex,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  rf_wen_idex, mem2reg_idex, rdest_ex, rs1_id, rs2_id,
               use_rs1_id, use_rs2_id, redirect_ex,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit up-counter that sticks at 0xFFFF instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event at the next rising edge
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_r;

    // Saturating event count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'd0;
        end else if (inc && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Load-use stall and control-redirect flush controller for a 5-stage
// pipeline. Responses are Mealy (same cycle as the hazard); the state only
// sequences the cycle that follows a stall or a redirect.
//   clk : pipeline clock
//   rst : asynchronous active-high reset
//   hz  : hazard_ctrl_if.slave (pipeline status in, stall/flush controls
//         and saturating stall/flush event counters out)
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    hz_state_e state_r;
    hz_state_e state_nxt_s;

    logic lu_s;
    logic pc_stall_s;
    logic ifid_stall_s;
    logic idex_bubble_s;
    logic ifid_flush_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign lu_s = load_use(hz.mem2reg_idex, hz.rf_wen_idex, hz.rdest_ex,
                           hz.rs1_id, hz.use_rs1_id,
                           hz.rs2_id, hz.use_rs2_id);

    // Control decode and next state. Reset forces every control low
    // immediately, independent of the clock.
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_bubble_s = 1'b0;
        ifid_flush_s  = 1'b0;
        stall_inc_s   = 1'b0;
        flush_inc_s   = 1'b0;
        state_nxt_s   = RUN;
        if (rst) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    // A redirect discards the stalled instruction anyway,
                    // so it takes priority over the load-use stall.
                    if (hz.redirect_ex) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        flush_inc_s   = 1'b1;
                        state_nxt_s   = FLUSH;
                    end else if (lu_s) begin
                        pc_stall_s    = 1'b1;
                        ifid_stall_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        stall_inc_s   = 1'b1;
                        state_nxt_s   = LSTALL;
                    end else begin
                        state_nxt_s   = RUN;
                    end
                end
                LSTALL: begin
                    // The load has moved to MEM; one bubble is enough.
                    state_nxt_s = RUN;
                end
                FLUSH: begin
                    // Squash the one fetch issued before the new PC landed.
                    ifid_flush_s = 1'b1;
                    state_nxt_s  = RUN;
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign hz.pc_stall    = pc_stall_s;
    assign hz.ifid_stall  = ifid_stall_s;
    assign hz.idex_bubble = idex_bubble_s;
    assign hz.ifid_flush  = ifid_flush_s;

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (hz.stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Each driven cycle pushes the expected
// outputs onto a scoreboard queue; the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       rf_wen;
        logic       mem2reg;
        logic [3:0] rdest;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use1;
        logic       use2;
        logic       redirect;
    } stim_t;

    typedef struct packed {
        logic        pc_stall;
        logic        ifid_stall;
        logic        idex_bubble;
        logic        ifid_flush;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } exp_t;

    logic clk;
    logic rst;

    hazard_ctrl_if hz_if ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb_q[$];

    // Reference model: 0 = RUN, 1 = LSTALL, 2 = FLUSH
    int          m_state = 0;
    logic [15:0] m_sc    = 16'd0;
    logic [15:0] m_fc    = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic m_lu(input stim_t s);
        return s.mem2reg && s.rf_wen &&
               ((s.use1 && (s.rs1 == s.rdest)) || (s.use2 && (s.rs2 == s.rdest)));
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ld(input logic [3:0] rd, input logic [3:0] r1,
                                 input logic u1, input logic [3:0] r2,
                                 input logic u2, input logic redir);
        stim_t s;
        s = '0;
        s.mem2reg = 1'b1; s.rf_wen = 1'b1; s.rdest = rd;
        s.rs1 = r1; s.use1 = u1; s.rs2 = r2; s.use2 = u2;
        s.redirect = redir;
        return s;
    endfunction

    // Called at posedge+1: drive, predict, compare at negedge, advance model.
    task automatic drive_cycle(input stim_t s);
        exp_t e;
        exp_t o;
        rst                = s.rst;
        hz_if.rf_wen_idex  = s.rf_wen;
        hz_if.mem2reg_idex = s.mem2reg;
        hz_if.rdest_ex     = s.rdest;
        hz_if.rs1_id       = s.rs1;
        hz_if.rs2_id       = s.rs2;
        hz_if.use_rs1_id   = s.use1;
        hz_if.use_rs2_id   = s.use2;
        hz_if.redirect_ex  = s.redirect;

        e = '0;
        if (s.rst) begin
            e.stall_cnt = 16'd0;
            e.flush_cnt = 16'd0;
        end else begin
            e.stall_cnt = m_sc;
            e.flush_cnt = m_fc;
            if (m_state == 0) begin
                if (s.redirect) begin
                    e.ifid_flush = 1'b1; e.idex_bubble = 1'b1;
                end else if (m_lu(s)) begin
                    e.pc_stall = 1'b1; e.ifid_stall = 1'b1; e.idex_bubble = 1'b1;
                end
            end else if (m_state == 2) begin
                e.ifid_flush = 1'b1;
            end
        end
        sb_q.push_back(e);

        @(negedge clk);
        e = sb_q.pop_front();
        check_val("pc_stall",    {31'd0, hz_if.pc_stall},    {31'd0, e.pc_stall});
        check_val("ifid_stall",  {31'd0, hz_if.ifid_stall},  {31'd0, e.ifid_stall});
        check_val("idex_bubble", {31'd0, hz_if.idex_bubble}, {31'd0, e.idex_bubble});
        check_val("ifid_flush",  {31'd0, hz_if.ifid_flush},  {31'd0, e.ifid_flush});
        check_val("stall_cnt",   {16'd0, hz_if.stall_cnt},   {16'd0, e.stall_cnt});
        check_val("flush_cnt",   {16'd0, hz_if.flush_cnt},   {16'd0, e.flush_cnt});
        o = e;

        @(posedge clk);
        if (s.rst) begin
            m_state = 0; m_sc = 16'd0; m_fc = 16'd0;
        end else begin
            case (m_state)
                0: begin
                    if (s.redirect) begin
                        m_state = 2;
                        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
                    end else if (m_lu(s)) begin
                        m_state = 1;
                        if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
                    end
                end
                default: m_state = 0;
            endcase
        end
        #1;
    endtask

    stim_t st;

    initial begin
        rst = 1'b1;
        st = idle();
        hz_if.rf_wen_idex = 1'b0; hz_if.mem2reg_idex = 1'b0;
        hz_if.rdest_ex = 4'd0; hz_if.rs1_id = 4'd0; hz_if.rs2_id = 4'd0;
        hz_if.use_rs1_id = 1'b0; hz_if.use_rs2_id = 1'b0; hz_if.redirect_ex = 1'b0;
        @(posedge clk); #1;

        // Reset state
        st = idle(); st.rst = 1'b1;
        drive_cycle(st);
        drive_cycle(st);
        drive_cycle(idle());

        // Load r3 in EX, ID reads rs1=3: one stall then clear
        drive_cycle(ld(4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0));
        drive_cycle(ld(4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0));
        check_val("lu_stall_cnt_1", {16'd0, hz_if.stall_cnt}, 32'd1);
        drive_cycle(idle());

        // Same load but rs1 unused: no stall
        drive_cycle(ld(4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0));
        check_val("no_use_stall_cnt", {16'd0, hz_if.stall_cnt}, 32'd1);
        // rs2 match
        drive_cycle(ld(4'd9, 4'd1, 1'b1, 4'd9, 1'b1, 1'b0));
        drive_cycle(idle());
        // not a load / not a register write
        st = ld(4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0); st.mem2reg = 1'b0;
        drive_cycle(st);
        st = ld(4'd5, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0); st.rf_wen = 1'b0;
        drive_cycle(st);

        // Redirect in RUN: flush+bubble, flush only, then clear
        st = idle(); st.redirect = 1'b1;
        drive_cycle(st);
        drive_cycle(ld(4'd2, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1));  // ignored in FLUSH
        drive_cycle(idle());
        check_val("redir_flush_cnt", {16'd0, hz_if.flush_cnt}, 32'd1);

        // Redirect and load-use together: redirect wins
        drive_cycle(ld(4'd7, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1));
        check_val("both_pc_stall", {31'd0, hz_if.pc_stall}, 32'd0);
        drive_cycle(idle());
        drive_cycle(idle());
        check_val("both_stall_cnt", {16'd0, hz_if.stall_cnt}, 32'd2);
        check_val("both_flush_cnt", {16'd0, hz_if.flush_cnt}, 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            st = '0;
            st.rf_wen   = 1'($urandom_range(0, 1));
            st.mem2reg  = 1'($urandom_range(0, 1));
            st.rdest    = 4'($urandom_range(0, 3));
            st.rs1      = 4'($urandom_range(0, 3));
            st.rs2      = 4'($urandom_range(0, 3));
            st.use1     = 1'($urandom_range(0, 1));
            st.use2     = 1'($urandom_range(0, 1));
            st.redirect = ($urandom_range(0, 5) == 0);
            drive_cycle(st);
        end
        drive_cycle(idle());
        drive_cycle(idle());

        // Saturation: preload stall counter near the top
        force dut.u_stall_cnt.count_r = 16'hFFFE;
        @(posedge clk); #1;
        release dut.u_stall_cnt.count_r;
        m_sc = 16'hFFFE;
        drive_cycle(idle());
        check_val("sat_preload", {16'd0, hz_if.stall_cnt}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(ld(4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0));
            drive_cycle(idle());
            check_val("sat_hold", {16'd0, hz_if.stall_cnt}, 32'h0000FFFF);
        end

        // Reset mid-FLUSH
        st = idle(); st.redirect = 1'b1;
        drive_cycle(st);
        st = idle(); st.rst = 1'b1;
        drive_cycle(st);
        drive_cycle(idle());
        check_val("rst_stall_cnt", {16'd0, hz_if.stall_cnt}, 32'd0);
        check_val("rst_flush_cnt", {16'd0, hz_if.flush_cnt}, 32'd0);
        // Back in RUN: a fresh load-use stalls at once
        drive_cycle(ld(4'd6, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0));
        drive_cycle(idle());
        check_val("post_rst_stall", {16'd0, hz_if.stall_cnt}, 32'd1);

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
